// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stall_ctrl_if
// Brief   : Request/response bundle between the pipeline stages and the
//           central stall/flush controller.
// Rev     : 1.0  initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
    parameter int PC_W = 32
);
    logic            stallreq_id;
    logic            stallreq_ex;
    logic            exc_req;
    logic [PC_W-1:0] exc_pc;
    logic [5:0]      stall;
    logic            flush;
    logic [PC_W-1:0] new_pc;
    logic            busy;
    logic            wdog_timeout;

    // The pipeline stages raise requests; the controller answers.
    modport master (
        output stallreq_id,
        output stallreq_ex,
        output exc_req,
        output exc_pc,
        input  stall,
        input  flush,
        input  new_pc,
        input  busy,
        input  wdog_timeout
    );

    modport slave (
        input  stallreq_id,
        input  stallreq_ex,
        input  exc_req,
        input  exc_pc,
        output stall,
        output flush,
        output new_pc,
        output busy,
        output wdog_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stall_ctrl
// Brief   : Central stall/flush controller for the 5-stage core. Optional
//           stall watchdog enabled by defining STALL_WDOG_EN.
// Rev     : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_MAX     = 64
) (
    input  wire               clk,
    input  wire               rst,
    pipe_stall_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("pipe_stall_ctrl: FLUSH_CYCLES out of range 1..15");
    end
    if (WDOG_MAX < 2 || WDOG_MAX > 255) begin : g_bad_wdog_max
        $error("pipe_stall_ctrl: WDOG_MAX out of range 2..255");
    end

    state_t          r_state;
    logic            r_flush;
    logic [PC_W-1:0] r_new_pc;
    logic            r_busy;
    logic [3:0]      r_flush_cnt;

    logic            w_any_req;
    logic [5:0]      w_stall;

    assign w_any_req = bus.stallreq_id | bus.stallreq_ex;

    // Combinational so a request freezes its stages in the very cycle it is raised.
    always_comb begin
        w_stall = 6'b000000;
        if (!rst && r_state != ST_FLUSH) begin
            if (bus.stallreq_ex)
                w_stall = 6'b001111;
            else if (bus.stallreq_id)
                w_stall = 6'b000111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush     <= 1'b0;
            r_new_pc    <= '0;
            r_busy      <= 1'b0;
            r_flush_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN, ST_STALL: begin
                    if (bus.exc_req) begin
                        r_state     <= ST_FLUSH;
                        r_new_pc    <= bus.exc_pc;
                        r_flush_cnt <= c_FLUSH_LOAD;
                        r_flush     <= 1'b1;
                        r_busy      <= 1'b1;
                    end else if (w_any_req) begin
                        r_state <= ST_STALL;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // exc_req is deliberately ignored here: no restart, no new target.
                    if (r_flush_cnt != 4'd0) begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end else begin
                        r_flush <= 1'b0;
                        if (w_any_req) begin
                            r_state <= ST_STALL;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_flush <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_WDOG_EN
    localparam logic [7:0] c_WDOG_LAST = 8'(WDOG_MAX - 1);

    logic [7:0] r_wdog_cnt;
    logic       r_wdog_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt <= 8'd0;
            r_wdog_to  <= 1'b0;
        end else begin
            r_wdog_to <= 1'b0;
            if (!w_any_req || (r_state != ST_FLUSH && bus.exc_req)) begin
                r_wdog_cnt <= 8'd0;
            end else if (r_state == ST_STALL) begin
                if (r_wdog_cnt == c_WDOG_LAST) begin
                    r_wdog_to  <= 1'b1;
                    r_wdog_cnt <= 8'd0;
                end else begin
                    r_wdog_cnt <= r_wdog_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.wdog_timeout = r_wdog_to;
`else
    assign bus.wdog_timeout = 1'b0;
`endif

    assign bus.stall  = w_stall;
    assign bus.flush  = r_flush;
    assign bus.new_pc = r_new_pc;
    assign bus.busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_stall_ctrl
// Brief   : Directed self-checking bench for pipe_stall_ctrl (FLUSH_CYCLES=3,
//           WDOG_MAX=8).
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int c_PC_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    pipe_stall_ctrl_if #(.PC_W(c_PC_W)) u_if ();

    pipe_stall_ctrl #(
        .PC_W         (c_PC_W),
        .FLUSH_CYCLES (3),
        .WDOG_MAX     (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the edge, return mid-cycle for sampling.
    task automatic drive(input logic r, input logic id, input logic ex,
                         input logic exc, input logic [31:0] pc);
        @(posedge clk);
        #1;
        rst              = r;
        u_if.stallreq_id = id;
        u_if.stallreq_ex = ex;
        u_if.exc_req     = exc;
        u_if.exc_pc      = pc;
        @(negedge clk);
    endtask

    initial begin
        u_if.stallreq_id = 1'b0;
        u_if.stallreq_ex = 1'b1;
        u_if.exc_req     = 1'b0;
        u_if.exc_pc      = '0;

        // Reset with a request pending: stall must stay clear
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_stall0", {26'd0, u_if.stall}, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_stall1", {26'd0, u_if.stall}, 32'h0);
        chk("rst_flush", {31'd0, u_if.flush}, 32'h0);
        chk("rst_newpc", u_if.new_pc, 32'h0);
        chk("rst_busy", {31'd0, u_if.busy}, 32'h0);
        chk("rst_wdog", {31'd0, u_if.wdog_timeout}, 32'h0);

        // Idle
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("idle_stall", {26'd0, u_if.stall}, 32'h0);
            chk("idle_flush", {31'd0, u_if.flush}, 32'h0);
            chk("idle_busy", {31'd0, u_if.busy}, 32'h0);
            chk("idle_newpc", u_if.new_pc, 32'h0);
        end

        // ID stall for 3 cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("id_stall", {26'd0, u_if.stall}, 32'h07);
            chk("id_busy", {31'd0, u_if.busy}, (i == 0) ? 32'h0 : 32'h1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("id_rel_stall", {26'd0, u_if.stall}, 32'h0);
        chk("id_rel_busy", {31'd0, u_if.busy}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("id_idle_busy", {31'd0, u_if.busy}, 32'h0);

        // ID and EX together: EX pattern wins
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("idex_stall", {26'd0, u_if.stall}, 32'h0F);
            chk("idex_busy", {31'd0, u_if.busy}, (i == 0) ? 32'h0 : 32'h1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("idex_rel_busy", {31'd0, u_if.busy}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("idex_idle_busy", {31'd0, u_if.busy}, 32'h0);

        // Exception with EX stall held; a second exception inside the window
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hBFC00380);
        chk("exc_stall", {26'd0, u_if.stall}, 32'h0F);
        chk("exc_flush", {31'd0, u_if.flush}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, (i == 1), (i == 1) ? 32'h12345678 : 32'h0);
            chk("fl_flush", {31'd0, u_if.flush}, 32'h1);
            chk("fl_newpc", u_if.new_pc, 32'hBFC00380);
            chk("fl_stall", {26'd0, u_if.stall}, 32'h0);
            chk("fl_busy", {31'd0, u_if.busy}, 32'h1);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("post_fl_flush", {31'd0, u_if.flush}, 32'h0);
        chk("post_fl_stall", {26'd0, u_if.stall}, 32'h0F);
        chk("post_fl_busy", {31'd0, u_if.busy}, 32'h1);
        chk("post_fl_newpc", u_if.new_pc, 32'hBFC00380);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("no_restart", {31'd0, u_if.flush}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("fl_rel_stall", {26'd0, u_if.stall}, 32'h0);
        chk("fl_rel_busy", {31'd0, u_if.busy}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("fl_idle_busy", {31'd0, u_if.busy}, 32'h0);
        chk("newpc_hold", u_if.new_pc, 32'hBFC00380);

        // Reset during the second flush cycle
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80000180);
        chk("rf_exc_flush", {31'd0, u_if.flush}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rf_flush1", {31'd0, u_if.flush}, 32'h1);
        chk("rf_newpc1", u_if.new_pc, 32'h80000180);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rf_flush2", {31'd0, u_if.flush}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rf_flush_clr", {31'd0, u_if.flush}, 32'h0);
        chk("rf_newpc_clr", u_if.new_pc, 32'h0);
        chk("rf_busy_clr", {31'd0, u_if.busy}, 32'h0);

`ifdef STALL_WDOG_EN
        // Long EX stall: pulses on the 9th and 17th cycles in STALL
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("wd_run", {31'd0, u_if.wdog_timeout}, (k == 9 || k == 17) ? 32'h1 : 32'h0);
            chk("wd_stall", {26'd0, u_if.stall}, 32'h0F);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        // Dropping the request restarts the count
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b0, (k != 7), 1'b0, 32'h0);
            chk("wd_drop", {31'd0, u_if.wdog_timeout}, 32'h0);
        end
`else
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("wd_off", {31'd0, u_if.wdog_timeout}, 32'h0);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Collects stall requests from ID and EX and the exception/flush request from MEM.
- Drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, plus the flush and new-PC redirect.
- Sequences multi-cycle flushes; optionally runs a stall watchdog.

Parameters:
- PC_W, 32, width of exc_pc / new_pc.
- FLUSH_CYCLES, 1, number of consecutive cycles flush is held (1..15).
- WDOG_MAX, 64, consecutive stall cycles before watchdog fires (2..255); only used with STALL_WDOG_EN.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, synchronous active-high reset.
- stallreq_id, input, 1, ID requests stall (load-use hazard).
- stallreq_ex, input, 1, EX requests stall (multi-cycle op in progress).
- exc_req, input, 1, MEM reports exception/eret; single-cycle pulse.
- exc_pc, input, PC_W, redirect target, valid with exc_req.
- stall, output, 6, bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved (always 0).
- flush, output, 1, clears if_id/id_ex/ex_mem/mem_wb to NOP values.
- new_pc, output, PC_W, PC to load while flush = 1.
- busy, output, 1, high when state is not RUN.
- wdog_timeout, output, 1, one-cycle pulse on stall watchdog expiry.

Behaviour:
- Reset (rst = 1 at posedge):
  - state = RUN; flush = 0; new_pc = 0; flush counter = 0; watchdog counter = 0; wdog_timeout = 0.
  - stall = 0 while rst is high, regardless of requests.
- States: RUN, STALL, FLUSH (2-bit encoding 0, 1, 2).
- stall output is combinational from the current requests, so a request holds its stages in the same cycle:
  - State FLUSH: stall = 6'b000000.
  - Otherwise, stallreq_ex = 1: stall = 6'b001111 (pc, if, id, ex held; mem proceeds with a bubble).
  - Otherwise, stallreq_id = 1: stall = 6'b000111.
  - Otherwise: stall = 6'b000000.
  - EX has priority over ID.
- Transitions, evaluated at posedge, highest priority first:
  - exc_req = 1 in RUN or STALL -> FLUSH.
    - Latch new_pc <= exc_pc and flush counter <= FLUSH_CYCLES-1.
    - Register flush <= 1, so flush is high starting the cycle after exc_req.
  - FLUSH with counter != 0: decrement the counter; flush stays 1.
  - FLUSH with counter == 0: flush <= 0.
    - Next state is STALL if any stallreq is high, else RUN.
  - RUN/STALL: next state is STALL if (stallreq_id | stallreq_ex), else RUN.
- flush is high for exactly FLUSH_CYCLES cycles per accepted exc_req.
- new_pc holds its value after flush drops.
- exc_req while in FLUSH is ignored: no restart and no new_pc update.
- exc_req in the same cycle as stall requests: the exception wins. stall reflects the requests that cycle; the next cycle is FLUSH.
- busy = (state != RUN); registered.
- Reset mid-FLUSH: flush drops to 0 on the next posedge; new_pc is cleared.

Optional Feature:
- Macro: STALL_WDOG_EN.
- Enabled:
  - An 8-bit counter increments every posedge with state == STALL and a stall request still high.
  - The counter clears on any cycle with no stall request, and on entering FLUSH.
  - When the counter reaches WDOG_MAX-1 with a request still high: wdog_timeout pulses for 1 cycle and the counter clears.
  - The stall vector is unaffected; the watchdog is an indication only.
- Disabled: no counter logic; wdog_timeout tied to 0.

Test Plan:
- Reset, then no requests for 5 cycles -> stall = 0, flush = 0, busy = 0, new_pc = 0.
- stallreq_id = 1 for 3 cycles -> stall = 6'b000111 on exactly those 3 cycles; busy = 1 from the cycle after the first request until one cycle after release.
- stallreq_id = 1 and stallreq_ex = 1 together for 2 cycles -> stall = 6'b001111 both cycles.
- FLUSH_CYCLES = 3, exc_req pulse with exc_pc = 32'hBFC00380, stallreq_ex held high:
  - stall = 6'b001111 in the exc_req cycle.
  - Then flush = 1 for 3 cycles with new_pc = 32'hBFC00380 and stall = 0.
  - Then state STALL, stall = 6'b001111.
  - A second exc_req inside the flush window is ignored.
- rst asserted during the 2nd flush cycle -> next cycle flush = 0, new_pc = 0, busy = 0.
- STALL_WDOG_EN, WDOG_MAX = 8, stallreq_ex held for 20 cycles -> wdog_timeout pulses on stall cycles 9 and 17; no pulse when the request is dropped at cycle 7 and reasserted.
